calc_soc: RTL and testbench
===========================

// Module: calc_soc
// PURPOSE
//  Top-level UART calculator SoC, 26 MHz board. Receives an ASCII expression
//  "<A><term><op><B><term>" on RXD (8N1) and evaluates it in the calculation
//  engine (instance CPU, holds registerFile[0:31]). Sends the decimal result
//  plus "\r\n" on TXD. LEDS is a single activity indicator.
// PARAMETERS
//  CLK_FREQ_HZ   26_000_000  system clock frequency
//  BAUD          115200      UART rate, both directions
//  CLKS_PER_BIT  CLK_FREQ_HZ/BAUD (=225)  integer-divided bit period in clocks
// PORTS
//  clk     in   1  system clock; all logic on its rising edge
//  resetn  in   1  reset, asynchronous, active-high (port keeps codebase name)
//  RXD     in   1  UART receive, idle high, asynchronous to clk
//  TXD     out  1  UART transmit, idle high
//  LEDS    out  1  toggles on every byte accepted by the receiver
// BEHAVIOUR
//  Reset (async assert, sync release): TXD=1, LEDS=0, FSM=ST_A.
//   - registerFile[0..31] cleared to 0.
//   - Any byte in flight on RX/TX is abandoned.
//  RX: RXD is double-flop synchronised.
//   - A start bit is accepted if RXD is still 0 at mid-bit (CLKS_PER_BIT/2).
//   - Data bits are sampled at mid-bit, LSB first.
//   - A byte is valid only if the stop bit is 1; otherwise it is dropped silently.
//   - Each valid byte produces a 1-clk rx_valid pulse, and LEDS toggles.
//  TX: 8N1, LSB first, each bit held CLKS_PER_BIT clocks.
//   - Has a tx_busy flag and accepts a new byte only while idle.
//  Register map (32-bit): r1=A, r2=B, r3=result, r4=remainder,
//   r5=op ASCII, r6=digit count of the current operand. Others read 0.
//  FSM:
//   ST_A: digit '0'-'9' sets A = A*10 + d (mod 2^32) and increments r6.
//     '\n'/'\r' has no effect.
//     op '+','-','*','/' with r6>0 stores op, clears r6, goes to ST_B;
//     with r6==0 the op is ignored.
//   ST_B: digit sets B = B*10 + d.
//     '\n'/'\r' with r6>0 goes to EXEC; with r6==0 it is ignored.
//     ops are ignored.
//   Other bytes are ignored in both states.
//   EXEC: computes into r3.
//     +, -: 1 clk, two's complement wrap.
//     *: low 32 bits of the product.
//     /: unsigned restoring divide, 32 clks; quotient to r3, remainder to r4.
//     B==0 with '/' sets an error flag and skips the divide.
//   FMT: converts r3 to decimal digits by repeated divide-by-10, most
//     significant digit first, no leading zeros; "0" if zero.
//     '-' and r3 sign bit set: emit '-' then the magnitude.
//     Other ops: r3 is unsigned.
//     Error: the digit string is the single char 'E'.
//   TX_OUT: sends the string, then 0x0D, 0x0A. Then clears r1..r6 and
//     returns to ST_A.
//  Bytes received during EXEC/FMT/TX_OUT are discarded; LEDS still toggles.
//  Latency: result transmission starts within 400 clks of the terminating
//   byte's stop bit.
//  Reset mid-operation aborts everything; TXD returns to 1 immediately.
// TESTING
//  1. Reset, send "1234\n\r" "/" "5\n\r" (gaps >= 1500 clks)
//     -> TXD emits "246\r\n"; r4=4.
//  2. Send "12+30\n" -> TXD "42\r\n"; LEDS toggles 6 times.
//  3. Send "3-10\r" -> TXD "-7\r\n". Send "65535*65537\n" -> "4294967295\r\n".
//  4. Send "7/0\n" -> TXD "E\r\n"; FSM back in ST_A with r1..r6=0.
//  5. Send "x+9\n" -> op ignored (r6=0 in ST_A), no TX.
//     Send a byte with a bad stop bit -> dropped, LEDS unchanged.
//  6. Assert resetn during TX of a result -> TXD=1 at once, LEDS=0, regs=0.
//     Then "2*3\n" -> "6\r\n".

Source files
------------

// File: rtl/calc_soc_if.sv
// Serial-side signal bundle of the UART calculator: receive line, transmit line
// and the activity LED.
interface calc_soc_if;
  logic RXD;
  logic TXD;
  logic LEDS;

  modport master (output RXD, input TXD, input LEDS);
  modport slave  (input RXD, output TXD, output LEDS);
endinterface

// File: rtl/calc_soc.sv
// UART calculator: parses "<A><term><op><B><term>" from RXD, evaluates it and
// returns the decimal result followed by CR LF on TXD.
module calc_soc #(
  parameter int unsigned CLK_FREQ_HZ = 26_000_000,
  parameter int unsigned BAUD        = 115200
) (
  input logic        clk,
  input logic        resetn,
  calc_soc_if.slave  bus
);
  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BitM1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HalfM1 = CW'(CLKS_PER_BIT / 2 - 1);

  localparam int RegA = 1, RegB = 2, RegRes = 3, RegRem = 4, RegOp = 5, RegCnt = 6;
  localparam logic [7:0] ChPlus = 8'h2B, ChMinus = 8'h2D, ChMul = 8'h2A, ChDiv = 8'h2F;
  localparam logic [7:0] ChCr = 8'h0D, ChLf = 8'h0A, ChE = 8'h45;

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [2:0] {StA, StB, StExec, StDiv, StFmtInit, StFmt, StTx} state_e;

  // ---------------- receiver ----------------
  logic          r_rx_m, r_rx_s;
  rx_state_e     r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift, r_rx_data;
  logic          r_rx_valid, r_leds;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_rx_m     <= 1'b1;
      r_rx_s     <= 1'b1;
      r_rx_state <= RxIdle;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_leds     <= 1'b0;
    end else begin
      r_rx_m     <= bus.RXD;
      r_rx_s     <= r_rx_m;
      r_rx_valid <= 1'b0;
      case (r_rx_state)
        RxIdle: begin
          r_rx_cnt <= '0;
          if (!r_rx_s) r_rx_state <= RxStart;
        end
        RxStart: begin
          if (r_rx_cnt == HalfM1) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_s ? RxIdle : RxData;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        RxData: begin
          if (r_rx_cnt == BitM1) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
            if (r_rx_bit == 3'd7) r_rx_state <= RxStop;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        RxStop: begin
          if (r_rx_cnt == BitM1) begin
            r_rx_cnt <= '0;
            if (r_rx_s) begin
              r_rx_valid <= 1'b1;
              r_rx_data  <= r_rx_shift;
              r_leds     <= ~r_leds;
              r_rx_state <= RxIdle;
            end else begin
              r_rx_state <= RxWaitHigh;  // framing error: let the line recover first
            end
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        default: if (r_rx_s) r_rx_state <= RxIdle;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  tx_state_e     r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          r_txd;
  logic          r_tx_start;
  logic [7:0]    r_tx_data;
  logic          w_tx_busy;

  assign w_tx_busy = (r_tx_state != TxIdle);

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_tx_state <= TxIdle;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else begin
      case (r_tx_state)
        TxIdle: begin
          r_txd    <= 1'b1;
          r_tx_cnt <= '0;
          if (r_tx_start) begin
            r_tx_shift <= r_tx_data;
            r_txd      <= 1'b0;
            r_tx_state <= TxStart;
          end
        end
        TxStart: begin
          if (r_tx_cnt == BitM1) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_state <= TxData;
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        TxData: begin
          if (r_tx_cnt == BitM1) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= TxStop;
            end else begin
              r_tx_bit   <= r_tx_bit + 1'b1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_txd      <= r_tx_shift[1];
            end
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        default: begin
          if (r_tx_cnt == BitM1) r_tx_state <= TxIdle;
          else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
      endcase
    end
  end

  assign bus.TXD  = r_txd;
  assign bus.LEDS = r_leds;

  // ---------------- calculation engine (CPU) ----------------
  state_e      r_state;
  logic [31:0] r_rf [32];
  logic        r_err, r_neg;
  logic [4:0]  r_div_cnt;
  logic [31:0] r_fmt_val;
  logic [7:0]  r_buf [16];
  logic [3:0]  r_len, r_idx;
  logic [1:0]  r_phase;

  logic        w_is_digit, w_is_op, w_is_eol, w_res_neg;
  logic [31:0] w_a_next, w_b_next, w_q10;
  logic [32:0] w_rem_sh, w_trial;
  logic [3:0]  w_dig;
  logic [7:0]  w_op;

  assign w_is_digit = (r_rx_data >= 8'h30) && (r_rx_data <= 8'h39);
  assign w_is_op    = (r_rx_data == ChPlus) || (r_rx_data == ChMinus) ||
                      (r_rx_data == ChMul)  || (r_rx_data == ChDiv);
  assign w_is_eol   = (r_rx_data == ChCr) || (r_rx_data == ChLf);
  assign w_a_next   = r_rf[RegA] * 32'd10 + {28'd0, r_rx_data[3:0]};
  assign w_b_next   = r_rf[RegB] * 32'd10 + {28'd0, r_rx_data[3:0]};
  assign w_op       = r_rf[RegOp][7:0];
  assign w_res_neg  = (w_op == ChMinus) && r_rf[RegRes][31];
  assign w_rem_sh   = {r_rf[RegRem], r_rf[RegRes][31]};
  assign w_trial    = w_rem_sh - {1'b0, r_rf[RegB]};
  // Exact floor(x/10) for any 32-bit x via reciprocal multiply.
  assign w_q10      = 32'(({32'd0, r_fmt_val} * 64'hCCCC_CCCD) >> 35);
  assign w_dig      = r_fmt_val[3:0] - w_q10[3:0] * 4'd10;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state    <= StA;
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
      for (int i = 0; i < 16; i++) r_buf[i] <= '0;
      r_err      <= 1'b0;
      r_neg      <= 1'b0;
      r_div_cnt  <= '0;
      r_fmt_val  <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_phase    <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        StA: if (r_rx_valid) begin
          if (w_is_digit) begin
            r_rf[RegA]   <= w_a_next;
            r_rf[RegCnt] <= r_rf[RegCnt] + 32'd1;
          end else if (w_is_op && r_rf[RegCnt] != 32'd0) begin
            r_rf[RegOp]  <= {24'd0, r_rx_data};
            r_rf[RegCnt] <= '0;
            r_state      <= StB;
          end
        end
        StB: if (r_rx_valid) begin
          if (w_is_digit) begin
            r_rf[RegB]   <= w_b_next;
            r_rf[RegCnt] <= r_rf[RegCnt] + 32'd1;
          end else if (w_is_eol && r_rf[RegCnt] != 32'd0) begin
            r_state <= StExec;
          end
        end
        StExec: begin
          r_state <= StFmtInit;
          case (w_op)
            ChPlus:  r_rf[RegRes] <= r_rf[RegA] + r_rf[RegB];
            ChMinus: r_rf[RegRes] <= r_rf[RegA] - r_rf[RegB];
            ChMul:   r_rf[RegRes] <= r_rf[RegA] * r_rf[RegB];
            default: begin
              if (r_rf[RegB] == 32'd0) begin
                r_err <= 1'b1;
              end else begin
                r_rf[RegRes] <= r_rf[RegA];
                r_rf[RegRem] <= '0;
                r_div_cnt    <= '0;
                r_state      <= StDiv;
              end
            end
          endcase
        end
        StDiv: begin
          // Dividend shifts out of r3 while quotient bits shift in.
          if (!w_trial[32]) begin
            r_rf[RegRem] <= w_trial[31:0];
            r_rf[RegRes] <= {r_rf[RegRes][30:0], 1'b1};
          end else begin
            r_rf[RegRem] <= w_rem_sh[31:0];
            r_rf[RegRes] <= {r_rf[RegRes][30:0], 1'b0};
          end
          r_div_cnt <= r_div_cnt + 5'd1;
          if (r_div_cnt == 5'd31) r_state <= StFmtInit;
        end
        StFmtInit: begin
          r_phase <= '0;
          if (r_err) begin
            r_buf[0] <= ChE;
            r_idx    <= 4'd1;
            r_state  <= StTx;
          end else begin
            r_neg     <= w_res_neg;
            r_fmt_val <= w_res_neg ? -r_rf[RegRes] : r_rf[RegRes];
            r_len     <= '0;
            r_state   <= StFmt;
          end
        end
        StFmt: begin
          // Digits are stored least significant first and sent in reverse.
          r_buf[r_len] <= {4'h3, w_dig};
          r_fmt_val    <= w_q10;
          r_len        <= r_len + 4'd1;
          if (w_q10 == 32'd0) begin
            if (r_neg) begin
              r_buf[r_len + 4'd1] <= ChMinus;
              r_idx               <= r_len + 4'd2;
            end else begin
              r_idx <= r_len + 4'd1;
            end
            r_state <= StTx;
          end
        end
        default: begin
          if (!w_tx_busy && !r_tx_start) begin
            r_tx_start <= 1'b1;
            if (r_idx != 4'd0) begin
              r_tx_data <= r_buf[r_idx - 4'd1];
              r_idx     <= r_idx - 4'd1;
            end else if (r_phase == 2'd0) begin
              r_tx_data <= ChCr;
              r_phase   <= 2'd1;
            end else begin
              r_tx_data <= ChLf;
              for (int i = RegA; i <= RegCnt; i++) r_rf[i] <= '0;
              r_err   <= 1'b0;
              r_state <= StA;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_calc_soc.sv
// Self-checking bench for calc_soc: drives UART expressions on RXD and scores
// the decoded TXD bytes against a queue of expected characters.
module tb_calc_soc;
  localparam int unsigned CLK_HZ = 26_000_000;
  localparam int unsigned BAUD   = 812_500;
  localparam int CPB = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  calc_soc_if bus ();

  calc_soc #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   led_toggles = 0;
  int   t_stop_end = 0;
  logic led_q;
  logic [7:0] q_exp[$];
  logic [7:0] q_got[$];
  int   tx_start_cyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!resetn && led_q !== bus.LEDS) led_toggles <= led_toggles + 1;
    led_q <= bus.LEDS;
  end

  // TXD decoder: a frame is kept only if no reset touched it.
  initial begin
    logic [7:0] b;
    bit ok;
    int t0;
    forever begin
      @(negedge bus.TXD);
      t0 = cyc;
      ok = (resetn == 1'b0);
      repeat (CPB / 2) @(negedge clk);
      if (bus.TXD !== 1'b0 || resetn) ok = 0;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = bus.TXD;
        if (resetn) ok = 0;
      end
      repeat (CPB) @(negedge clk);
      if (bus.TXD !== 1'b1 || resetn) ok = 0;
      if (ok) begin
        q_got.push_back(b);
        tx_start_cyc.push_back(t0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    @(negedge clk);
    bus.RXD = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RXD = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.RXD = good_stop;
    repeat (CPB) @(negedge clk);
    bus.RXD = 1'b1;
    t_stop_end = cyc;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic expect_result(input logic [31:0] a, input logic [31:0] b, input byte op);
    string s;
    logic [31:0] r, m;
    r = 32'd0;
    if (op == "/" && b == 32'd0) s = "E";
    else begin
      case (op)
        "+":     r = a + b;
        "-":     r = a - b;
        "*":     r = a * b;
        default: r = a / b;
      endcase
      if (op == "-" && r[31]) begin
        m = -r;
        s = {"-", $sformatf("%0d", m)};
      end else s = $sformatf("%0d", r);
    end
    for (int i = 0; i < s.len(); i++) q_exp.push_back(s[i]);
    q_exp.push_back(8'h0D);
    q_exp.push_back(8'h0A);
  endtask

  task automatic check_output(input string name);
    int budget, t;
    logic [7:0] g, e;
    budget = q_exp.size() * 12 * CPB + 800;
    t = 0;
    while (q_got.size() < q_exp.size() && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (q_got.size() < q_exp.size()) begin
      n_bad++;
      $display("FAIL %s timeout: got %0d bytes, required %0d", name, q_got.size(), q_exp.size());
    end
    while (q_exp.size() > 0 && q_got.size() > 0) begin
      g = q_got.pop_front();
      e = q_exp.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL %s byte: got 0x%02h, required 0x%02h", name, g, e);
      end
    end
    q_exp.delete();
  endtask

  task automatic check_regs_clear(input string name);
    for (int i = 1; i <= 6; i++) begin
      n_cmp++;
      if (dut.r_rf[i] !== 32'd0) begin
        n_bad++;
        $display("FAIL %s r%0d: got 0x%08h, required 0", name, i, dut.r_rf[i]);
      end
    end
  endtask

  task automatic test_reset();
    bus.RXD = 1'b1;
    #2 resetn = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bus.TXD !== 1'b1 || bus.LEDS !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pins: TXD=%b LEDS=%b, required TXD=1 LEDS=0", bus.TXD, bus.LEDS);
    end
    n_cmp++;
    if (int'(dut.r_state) !== 0) begin
      n_bad++;
      $display("FAIL reset_state: got %0d, required 0", int'(dut.r_state));
    end
    check_regs_clear("reset");
    resetn = 1'b0;
    repeat (4 * CPB) @(negedge clk);
  endtask

  task automatic test_divide();
    send_str("1234\n\r");
    send_str("/5\n");
    expect_result(32'd1234, 32'd5, "/");
    n_cmp++;
    if (dut.r_rf[4] !== 32'd4) begin
      n_bad++;
      $display("FAIL div_remainder: got %0d, required 4", dut.r_rf[4]);
    end
    send_str("\r");
    check_output("divide");
  endtask

  task automatic test_add();
    int leds0, lat;
    leds0 = led_toggles;
    tx_start_cyc.delete();
    send_str("12+30\n");
    expect_result(32'd12, 32'd30, "+");
    check_output("add");
    lat = (tx_start_cyc.size() > 0) ? tx_start_cyc[0] - t_stop_end : 99999;
    n_cmp++;
    if (lat > 400) begin
      n_bad++;
      $display("FAIL latency: got %0d clks, required <= 400", lat);
    end
    n_cmp++;
    if (led_toggles - leds0 !== 6) begin
      n_bad++;
      $display("FAIL led_toggles: got %0d, required 6", led_toggles - leds0);
    end
  endtask

  task automatic test_sub_mul();
    send_str("3-10\r");
    expect_result(32'd3, 32'd10, "-");
    check_output("sub_neg");
    send_str("65535*65537\n");
    expect_result(32'd65535, 32'd65537, "*");
    check_output("mul_max");
  endtask

  task automatic test_div_zero();
    send_str("7/0\n");
    expect_result(32'd7, 32'd0, "/");
    check_output("div_zero");
    n_cmp++;
    if (int'(dut.r_state) !== 0) begin
      n_bad++;
      $display("FAIL div_zero_state: got %0d, required 0", int'(dut.r_state));
    end
    check_regs_clear("div_zero");
    repeat (12 * CPB) @(negedge clk);
  endtask

  task automatic test_ignored();
    int leds0;
    logic leds_lvl;
    send_str("x+9\n");
    repeat (12 * CPB) @(negedge clk);
    n_cmp++;
    if (q_got.size() != 0) begin
      n_bad++;
      $display("FAIL ignore_op_tx: got %0d bytes, required 0", q_got.size());
    end
    n_cmp++;
    if (dut.r_rf[1] !== 32'd9 || dut.r_rf[6] !== 32'd1) begin
      n_bad++;
      $display("FAIL ignore_op_regs: r1=%0d r6=%0d, required r1=9 r6=1", dut.r_rf[1], dut.r_rf[6]);
    end
    leds0 = led_toggles;
    leds_lvl = bus.LEDS;
    send_byte(8'h35, 1'b0);
    repeat (4 * CPB) @(negedge clk);
    n_cmp++;
    if (led_toggles != leds0 || bus.LEDS !== leds_lvl) begin
      n_bad++;
      $display("FAIL bad_stop_leds: toggles %0d, required %0d", led_toggles - leds0, 0);
    end
    n_cmp++;
    if (dut.r_rf[1] !== 32'd9) begin
      n_bad++;
      $display("FAIL bad_stop_dropped: r1=%0d, required 9", dut.r_rf[1]);
    end
  endtask

  task automatic test_reset_mid_tx();
    int t;
    @(negedge clk) resetn = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    send_str("123+1\n");
    t = 0;
    while (q_got.size() < 1 && t < 20 * CPB) begin
      @(negedge clk);
      t++;
    end
    repeat (3 * CPB) @(negedge clk);
    resetn = 1'b1;
    #1;
    n_cmp++;
    if (bus.TXD !== 1'b1 || bus.LEDS !== 1'b0) begin
      n_bad++;
      $display("FAIL midtx_reset_pins: TXD=%b LEDS=%b, required TXD=1 LEDS=0", bus.TXD, bus.LEDS);
    end
    check_regs_clear("midtx_reset");
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    q_got.delete();
    q_exp.delete();
    send_str("2*3\n");
    expect_result(32'd2, 32'd3, "*");
    check_output("after_reset");
  endtask

  initial begin
    test_reset();
    test_divide();
    test_add();
    test_sub_mul();
    test_div_zero();
    test_ignored();
    test_reset_mid_tx();
    repeat (12 * CPB) @(negedge clk);
    n_cmp++;
    if (q_got.size() != 0) begin
      n_bad++;
      $display("FAIL extra_tx: got %0d unexpected bytes, required 0", q_got.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
